// File: rtl/branch_resolve_unit.sv
// Execute-stage control-flow resolver: target/link computation, fetch redirect handshake,
// timed flush of younger stages and a saturating taken-redirect counter. All outputs registered.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic             br_taken_in,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_imm,
  input  logic [31:0]      br_rs1,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             br_flush,
  output logic             br_stall,
  output logic [31:0]      br_link,
  output logic             br_link_valid,
  output logic             br_misalign,
  output logic [CNT_W-1:0] br_taken_cnt
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [3:0]        fcnt, fcnt_nxt;
  logic              rv_nxt, lv_nxt, mis_nxt;
  logic [31:0]       rpc_nxt, link_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              is_jump, taken;
  logic [31:0]       target;

  always_comb begin
    is_jump = br_type[1];
    taken   = (br_type == 2'b01 && br_taken_in) || is_jump;
    // JALR clears bit 0 of the computed address before the alignment check
    target  = (br_type == 2'b11) ? ((br_rs1 + br_imm) & ~32'h1) : (br_pc + br_imm);
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    rv_nxt    = redirect_valid;
    rpc_nxt   = redirect_pc;
    link_nxt  = br_link;
    lv_nxt    = 1'b0;
    mis_nxt   = 1'b0;
    cnt_nxt   = br_taken_cnt;
    case (state)
      IDLE: begin
        if (br_valid) begin
          if (is_jump) begin
            lv_nxt   = 1'b1;
            link_nxt = br_pc + 32'd4;
          end
          if (taken) begin
            if (target[1:0] != 2'b00) begin
              mis_nxt = 1'b1;
            end else begin
              rv_nxt    = 1'b1;
              rpc_nxt   = target;
              state_nxt = REDIRECT;
            end
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          rv_nxt = 1'b0;
          if (br_taken_cnt != {CNT_W{1'b1}})
            cnt_nxt = br_taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (FLUSH_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = FLUSH;
            fcnt_nxt  = FLUSH_CYCLES[3:0];
          end
        end
      end
      FLUSH: begin
        // fcnt holds the number of flush cycles still to be shown, including the current one
        if (fcnt <= 4'd1) state_nxt = IDLE;
        else              fcnt_nxt  = fcnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      fcnt           <= 4'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      br_flush       <= 1'b0;
      br_stall       <= 1'b0;
      br_link        <= 32'd0;
      br_link_valid  <= 1'b0;
      br_misalign    <= 1'b0;
      br_taken_cnt   <= {CNT_W{1'b0}};
    end else begin
      state          <= state_nxt;
      fcnt           <= fcnt_nxt;
      redirect_valid <= rv_nxt;
      redirect_pc    <= rpc_nxt;
      br_flush       <= (state_nxt == FLUSH);
      br_stall       <= (state_nxt != IDLE);
      br_link        <= link_nxt;
      br_link_valid  <= lv_nxt;
      br_misalign    <= mis_nxt;
      br_taken_cnt   <= cnt_nxt;
    end
  end

endmodule
